// File: rtl/novacore_cfg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : novacore_cfg_pkg
// Description : Shared types and default widths for the NovaCORE configuration
//               sequencer (state encoding, host-word layout).
// Revision    : 1.0 - initial release
// ============================================================================
package novacore_cfg_pkg;

    localparam int C_DEF_BUS_W = 58;
    localparam int C_DEF_UID_W = 8;
    localparam int C_DEF_DIM_W = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_DSW   = 3'd2,
        ST_SETUP = 3'd3,
        ST_HI    = 3'd4,
        ST_LO    = 3'd5,
        ST_DONE  = 3'd6
    } cfg_state_e;

    typedef struct packed {
        logic [C_DEF_BUS_W-1:0] data;
        logic [C_DEF_UID_W-1:0] uid;
        logic [C_DEF_DIM_W-1:0] dim;
        logic                   last;
    } host_word_t;

endpackage
`default_nettype wire

// File: rtl/novacore_cfg_halfper_timer.sv
`default_nettype none
// ============================================================================
// Module      : novacore_cfg_halfper_timer
// Description : Down-counter reloaded with HALF_PER-1; expire marks the last
//               cycle of a half-period phase.
// Revision    : 1.0 - initial release
// ============================================================================
module novacore_cfg_halfper_timer #(
    parameter int HALF_PER = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    localparam int              C_TW     = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
    localparam logic [C_TW-1:0] C_RELOAD = C_TW'(HALF_PER - 1);

    logic [C_TW-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= C_RELOAD;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - C_TW'(1);
        end
    end

    assign expire = (r_cnt == '0);

endmodule
`default_nettype wire

// File: rtl/novacore_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : novacore_cfg_sequencer
// Description : Serialises host configuration words onto the NovaCORE fabric
//               configuration port. Optional XOR checksum: NOVACORE_CFG_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module novacore_cfg_sequencer
    import novacore_cfg_pkg::*;
#(
    parameter int BUS_W     = C_DEF_BUS_W,
    parameter int UID_W     = C_DEF_UID_W,
    parameter int DIM_W     = C_DEF_DIM_W,
    parameter int NUM_CELLS = 49,
    parameter int HALF_PER  = 2,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             h_valid,
    output logic             h_ready,
    input  logic [BUS_W-1:0] h_data,
    input  logic [UID_W-1:0] h_uid,
    input  logic [DIM_W-1:0] h_dim,
    input  logic             h_last,
    output logic             mode,
    output logic [BUS_W-1:0] c_bus,
    output logic [UID_W-1:0] c_uid,
    output logic             c_clk,
    output logic [DIM_W-1:0] c_dimension,
    output logic             c_dimswitch,
    output logic             busy,
    output logic             done,
    output logic             err,
`ifdef NOVACORE_CFG_CHECKSUM_EN
    input  logic [BUS_W-1:0] exp_chk,
    output logic             chk_err,
`endif
    output logic [CNT_W-1:0] word_cnt
);

    localparam logic [UID_W-1:0] C_NUM_CELLS = UID_W'(NUM_CELLS);
    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

    cfg_state_e r_state;
    cfg_state_e w_nxt;
    logic       r_last;
    logic       w_hs;
    logic       w_bad_uid;
    logic       w_start_ok;
    logic       w_hi_entry;
    logic       w_expire;
    logic       w_tmr_load;

    assign w_hs       = (r_state == ST_LOAD) && h_valid && !abort;
    assign w_bad_uid  = (h_uid >= C_NUM_CELLS);
    assign w_start_ok = (r_state == ST_IDLE) && start && !abort;
    assign w_hi_entry = (r_state == ST_SETUP) && (w_nxt == ST_HI);
    // Every DSW/HI/LO entry restarts the shared half-period timer.
    assign w_tmr_load = (w_nxt != r_state) && (w_nxt inside {ST_DSW, ST_HI, ST_LO});

    novacore_cfg_halfper_timer #(
        .HALF_PER (HALF_PER)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (w_tmr_load),
        .expire (w_expire)
    );

    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (start) w_nxt = ST_LOAD;
            ST_LOAD: begin
                if (h_valid) begin
                    if (w_bad_uid)                w_nxt = h_last ? ST_DONE : ST_LOAD;
                    else if (h_dim != c_dimension) w_nxt = ST_DSW;
                    else                          w_nxt = ST_SETUP;
                end
            end
            ST_DSW:   if (w_expire) w_nxt = ST_SETUP;
            ST_SETUP: w_nxt = ST_HI;
            ST_HI:    if (w_expire) w_nxt = ST_LO;
            ST_LO:    if (w_expire) w_nxt = r_last ? ST_DONE : ST_LOAD;
            ST_DONE:  w_nxt = ST_IDLE;
            default:  w_nxt = ST_IDLE;
        endcase
        if (abort) w_nxt = ST_IDLE;
    end

    // Outputs are decoded from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_last      <= 1'b0;
            mode        <= 1'b1;
            busy        <= 1'b0;
            h_ready     <= 1'b0;
            c_clk       <= 1'b0;
            c_dimswitch <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            word_cnt    <= '0;
            c_bus       <= '0;
            c_uid       <= '0;
            c_dimension <= '0;
        end else begin
            r_state     <= w_nxt;
            mode        <= (w_nxt == ST_IDLE) || (w_nxt == ST_DONE);
            busy        <= (w_nxt != ST_IDLE);
            h_ready     <= (w_nxt == ST_LOAD);
            c_clk       <= (w_nxt == ST_HI);
            c_dimswitch <= (w_nxt == ST_DSW);
            done        <= (w_nxt == ST_DONE);
            if (w_start_ok) begin
                err      <= 1'b0;
                word_cnt <= '0;
            end
            if (w_hs) begin
                if (w_bad_uid) begin
                    err <= 1'b1;
                end else begin
                    c_bus       <= h_data;
                    c_uid       <= h_uid;
                    c_dimension <= h_dim;
                    r_last      <= h_last;
                end
            end
            if (w_hi_entry && (word_cnt != C_CNT_MAX)) begin
                word_cnt <= word_cnt + CNT_W'(1);
            end
        end
    end

`ifdef NOVACORE_CFG_CHECKSUM_EN
    logic [BUS_W-1:0] r_xor;
    logic [BUS_W-1:0] r_exp;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_xor   <= '0;
            r_exp   <= '0;
            chk_err <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_xor   <= '0;
                r_exp   <= exp_chk;
                chk_err <= 1'b0;
            end
            if (w_hi_entry) begin
                r_xor <= r_xor ^ c_bus;
            end
            if ((w_nxt == ST_DONE) && (r_state != ST_DONE)) begin
                chk_err <= (r_xor != r_exp);
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_novacore_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_novacore_cfg_sequencer
// Description : Self-checking bench: vector table, corner-case sequences and
//               randomized sessions against a word-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_novacore_cfg_sequencer;
    import novacore_cfg_pkg::*;

    localparam int BUS_W     = 58;
    localparam int UID_W     = 8;
    localparam int DIM_W     = 2;
    localparam int NUM_CELLS = 49;
    localparam int HP        = 2;
    localparam int CNT_W     = 8;
    localparam int LOG_N     = 1024;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             h_valid = 1'b0;
    logic [BUS_W-1:0] h_data = '0;
    logic [UID_W-1:0] h_uid = '0;
    logic [DIM_W-1:0] h_dim = '0;
    logic             h_last = 1'b0;
    logic             h_ready, mode, c_clk, c_dimswitch, busy, done, err;
    logic [BUS_W-1:0] c_bus;
    logic [UID_W-1:0] c_uid;
    logic [DIM_W-1:0] c_dimension;
    logic [CNT_W-1:0] word_cnt;
`ifdef NOVACORE_CFG_CHECKSUM_EN
    logic [BUS_W-1:0] exp_chk = '0;
    logic             chk_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [DIM_W-1:0] m_dim = '0;

    always #5 clk = ~clk;

    novacore_cfg_sequencer #(
        .BUS_W(BUS_W), .UID_W(UID_W), .DIM_W(DIM_W),
        .NUM_CELLS(NUM_CELLS), .HALF_PER(HP), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .h_valid(h_valid), .h_ready(h_ready), .h_data(h_data), .h_uid(h_uid),
        .h_dim(h_dim), .h_last(h_last), .mode(mode), .c_bus(c_bus), .c_uid(c_uid),
        .c_clk(c_clk), .c_dimension(c_dimension), .c_dimswitch(c_dimswitch),
        .busy(busy), .done(done), .err(err),
`ifdef NOVACORE_CFG_CHECKSUM_EN
        .exp_chk(exp_chk), .chk_err(chk_err),
`endif
        .word_cnt(word_cnt)
    );

    // Fabric-side observer: logs each strobe and counts protocol violations.
    int mon_strobes = 0, mon_bus_viol = 0, mon_hi_bad = 0, mon_dsw_bad = 0;
    int mon_dsw_cnt = 0, mon_done = 0, hi_run = 0, dsw_run = 0;
    logic p_clk = 1'b0, p_dsw = 1'b0;
    logic [BUS_W+UID_W+DIM_W-1:0] p_word = '0;
    logic [BUS_W+UID_W+DIM_W-1:0] mon_log [0:LOG_N-1];

    always @(negedge clk) begin
        p_clk  <= c_clk;
        p_dsw  <= c_dimswitch;
        p_word <= {c_bus, c_uid, c_dimension};
        if (rst_n) begin
            if (c_clk && !p_clk) begin
                mon_log[mon_strobes % LOG_N] <= {c_bus, c_uid, c_dimension};
                mon_strobes <= mon_strobes + 1;
            end
            if (c_clk && p_clk && ({c_bus, c_uid, c_dimension} != p_word))
                mon_bus_viol <= mon_bus_viol + 1;
            if (c_clk) hi_run <= hi_run + 1;
            else begin
                hi_run <= 0;
                if (p_clk && hi_run != HP) mon_hi_bad <= mon_hi_bad + 1;
            end
            if (c_dimswitch) dsw_run <= dsw_run + 1;
            else begin
                dsw_run <= 0;
                if (p_dsw) begin
                    mon_dsw_cnt <= mon_dsw_cnt + 1;
                    if (dsw_run != HP) mon_dsw_bad <= mon_dsw_bad + 1;
                end
            end
            if (done) mon_done <= mon_done + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offers one word (with random valid gaps), then returns the number of
    // cycles from the handshake cycle until h_ready or done is seen again.
    task automatic send_word(input host_word_t w, input int gap_pct, output int lat);
        bit hs = 1'b0;
        int t = 0;
        h_data = w.data; h_uid = w.uid; h_dim = w.dim; h_last = w.last;
        while (!hs && t < 200) begin
            h_valid = ($urandom_range(99) >= gap_pct);
            hs = h_valid && h_ready;
            tick();
            t++;
        end
        h_valid = 1'b0;
        lat = 0;
        if (!hs) begin
            checks++;
            errors++;
            $display("FAIL handshake: none after %0d cycles, required one", t);
        end else begin
            if (w.uid < NUM_CELLS) m_dim = w.dim;
            lat = 1;
            while (!(h_ready || done) && lat < 100) begin
                tick();
                lat++;
            end
        end
    endtask

    typedef struct {
        host_word_t       w;
        int               lat;
        int               str;
        logic             err;
        int               cnt;
        logic [BUS_W-1:0] bus;
        logic [DIM_W-1:0] dim;
        logic             dn;
    } vec_t;

    vec_t tbl [7];

    function automatic vec_t mkv(input logic [BUS_W-1:0] d, input int u, input int dm, input bit l,
                                 input int lat, input int str, input bit e, input int cnt,
                                 input logic [BUS_W-1:0] bus, input int dim, input bit dn);
        vec_t v;
        v.w.data = d; v.w.uid = u[UID_W-1:0]; v.w.dim = dm[DIM_W-1:0]; v.w.last = l;
        v.lat = lat; v.str = str; v.err = e; v.cnt = cnt;
        v.bus = bus; v.dim = dim[DIM_W-1:0]; v.dn = dn;
        return v;
    endfunction

    task automatic run_random(input string tag, input int n, input int bad_pct, input int gap_pct);
        host_word_t words[$];
        host_word_t w;
        int good = 0, lat = 0, exp_lat = 0, lat_bad = 0, word_bad = 0, gi = 0;
        int s0, hb0, bv0, db0;
        logic merr = 1'b0;
        logic [BUS_W-1:0] mxor = '0, mbus = '0;
`ifdef NOVACORE_CFG_CHECKSUM_EN
        logic [BUS_W-1:0] flip = '0;
        bit same;
`endif
        for (int i = 0; i < n; i++) begin
            w.data = BUS_W'({$urandom(), $urandom()});
            if ($urandom_range(99) < bad_pct) begin
                w.uid = UID_W'($urandom_range(255, NUM_CELLS));
                merr = 1'b1;
            end else begin
                w.uid = UID_W'($urandom_range(NUM_CELLS - 1));
                good++;
                mxor ^= w.data;
                mbus = w.data;
            end
            w.dim  = DIM_W'($urandom_range(3));
            w.last = (i == n - 1);
            words.push_back(w);
        end
`ifdef NOVACORE_CFG_CHECKSUM_EN
        same = bit'($urandom_range(1));
        flip[$urandom_range(BUS_W - 1)] = 1'b1;
        exp_chk = same ? mxor : (mxor ^ flip);
`endif
        s0 = mon_strobes; hb0 = mon_hi_bad; bv0 = mon_bus_viol; db0 = mon_dsw_bad;
        do_start();
        foreach (words[i]) begin
            if (words[i].uid >= NUM_CELLS) exp_lat = 1;
            else exp_lat = 2 * HP + 2 + ((words[i].dim != m_dim) ? HP : 0);
            send_word(words[i], gap_pct, lat);
            if (lat != exp_lat) lat_bad++;
        end
        foreach (words[i]) begin
            if (words[i].uid < NUM_CELLS) begin
                if (mon_log[(s0 + gi) % LOG_N] !== {words[i].data, words[i].uid, words[i].dim})
                    word_bad++;
                gi++;
            end
        end
        check($sformatf("%s_latency_errs", tag), lat_bad, 0);
        check($sformatf("%s_strobes", tag), mon_strobes - s0, good);
        check($sformatf("%s_strobe_word_errs", tag), word_bad, 0);
        check($sformatf("%s_word_cnt", tag), word_cnt, (good > 255) ? 255 : good);
        check($sformatf("%s_err", tag), err, merr);
        check($sformatf("%s_done", tag), done, 1);
        check($sformatf("%s_mode", tag), mode, 1);
        check($sformatf("%s_hi_width", tag), mon_hi_bad - hb0, 0);
        check($sformatf("%s_dsw_width", tag), mon_dsw_bad - db0, 0);
        check($sformatf("%s_bus_stable", tag), mon_bus_viol - bv0, 0);
        if (good > 0) check($sformatf("%s_c_bus", tag), c_bus, mbus);
`ifdef NOVACORE_CFG_CHECKSUM_EN
        check($sformatf("%s_chk_err", tag), chk_err, !same);
`endif
        tick();
    endtask

`ifdef NOVACORE_CFG_CHECKSUM_EN
    task automatic run_chk(input logic [BUS_W-1:0] e, input logic exp_err);
        host_word_t w;
        int lat;
        exp_chk = e;
        do_start();
        for (int k = 0; k < 3; k++) begin
            w.data = BUS_W'(1) << k;
            w.uid  = UID_W'(k + 1);
            w.dim  = m_dim;
            w.last = (k == 2);
            send_word(w, 0, lat);
        end
        check("chk_done", done, 1);
        check("chk_err", chk_err, exp_err);
        tick();
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required test completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] obs_clk, obs_done, obs_mode;
        logic [6:0] exp_clk, exp_done, exp_mode;
        host_word_t w;
        int lat, s0, d0, dsw0, hb0, bv0, t;

        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_mode", mode, 1);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_h_ready", h_ready, 0);
        check("rst_c_bus", c_bus, 0);
        check("rst_c_uid", c_uid, 0);
        check("rst_c_clk", c_clk, 0);
        check("rst_c_dimension", c_dimension, 0);
        check("rst_c_dimswitch", c_dimswitch, 0);
        check("rst_word_cnt", word_cnt, 0);
`ifdef NOVACORE_CFG_CHECKSUM_EN
        check("rst_chk_err", chk_err, 0);
`endif

        // Single word: cycle-exact strobe, done and mode timing.
        do_start();
        check("start_h_ready", h_ready, 1);
        check("start_mode", mode, 0);
        check("start_busy", busy, 1);
        h_data = 58'h2A; h_uid = 8'd5; h_dim = 2'd0; h_last = 1'b1; h_valid = 1'b1;
        tick();
        h_valid = 1'b0;
        for (int k = 0; k < 7; k++) begin
            obs_clk[k] = c_clk; obs_done[k] = done; obs_mode[k] = mode;
            tick();
        end
        exp_clk = 7'b0000110; exp_done = 7'b0100000; exp_mode = 7'b1100000;
        check("single_c_clk_trace", obs_clk, exp_clk);
        check("single_done_trace", obs_done, exp_done);
        check("single_mode_trace", obs_mode, exp_mode);
        check("single_word_cnt", word_cnt, 1);
        check("single_mode_after", mode, 1);
        check("single_busy_after", busy, 0);
        check("single_c_bus", c_bus, 58'h2A);
        check("single_c_uid", c_uid, 5);

        // Vector table: one session mixing dimension switches and bad UIDs.
        tbl[0] = mkv(58'h2A,  5,   0, 0, 6, 1, 0, 1, 58'h2A,  0, 0);
        tbl[1] = mkv(58'h15,  3,   2, 0, 8, 1, 0, 2, 58'h15,  2, 0);
        tbl[2] = mkv(58'h3FF, 49,  1, 0, 1, 0, 1, 2, 58'h15,  2, 0);
        tbl[3] = mkv(58'h77,  48,  2, 0, 6, 1, 1, 3, 58'h77,  2, 0);
        tbl[4] = mkv(58'h1,   0,   1, 0, 8, 1, 1, 4, 58'h1,   1, 0);
        tbl[5] = mkv(58'hABC, 200, 0, 0, 1, 0, 1, 4, 58'h1,   1, 0);
        tbl[6] = mkv(58'h5,   7,   1, 1, 6, 1, 1, 5, 58'h5,   1, 1);
        dsw0 = mon_dsw_cnt; hb0 = mon_hi_bad; bv0 = mon_bus_viol;
        do_start();
        for (int i = 0; i < 7; i++) begin
            s0 = mon_strobes;
            send_word(tbl[i].w, 0, lat);
            check($sformatf("tbl%0d_latency", i), lat, tbl[i].lat);
            check($sformatf("tbl%0d_strobes", i), mon_strobes - s0, tbl[i].str);
            check($sformatf("tbl%0d_err", i), err, tbl[i].err);
            check($sformatf("tbl%0d_word_cnt", i), word_cnt, tbl[i].cnt);
            check($sformatf("tbl%0d_c_bus", i), c_bus, tbl[i].bus);
            check($sformatf("tbl%0d_c_dimension", i), c_dimension, tbl[i].dim);
            check($sformatf("tbl%0d_done", i), done, tbl[i].dn);
        end
        tick();
        check("tbl_dimswitch_pulses", mon_dsw_cnt - dsw0, 2);
        check("tbl_hi_width", mon_hi_bad - hb0, 0);
        check("tbl_bus_stable", mon_bus_viol - bv0, 0);
        check("tbl_idle_busy", busy, 0);

        // Abort while the strobe is high, then abort racing a start.
        do_start();
        h_data = 58'h155; h_uid = 8'd9; h_dim = m_dim; h_last = 1'b0; h_valid = 1'b1;
        tick();
        h_valid = 1'b0;
        t = 0;
        while (!c_clk && t < 20) begin
            tick();
            t++;
        end
        check("abort_reached_hi", c_clk, 1);
        d0 = mon_done;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_c_clk", c_clk, 0);
        check("abort_mode", mode, 1);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_c_dimswitch", c_dimswitch, 0);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_over_start_busy", busy, 0);
        check("abort_over_start_word_cnt", word_cnt, 1);
        repeat (6) tick();
        check("abort_no_done", mon_done - d0, 0);

        do_start();
        w.data = 58'h3C; w.uid = 8'd10; w.dim = m_dim; w.last = 1'b0;
        send_word(w, 0, lat);
        check("post_abort_latency", lat, 2 * HP + 2);
        check("post_abort_word_cnt", word_cnt, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_ignored_word_cnt", word_cnt, 1);
        check("start_ignored_h_ready", h_ready, 1);
        w.data = 58'h3D; w.uid = 8'd11; w.last = 1'b1;
        send_word(w, 0, lat);
        check("post_abort_last_latency", lat, 2 * HP + 2);
        check("post_abort_done", done, 1);
        check("post_abort_word_cnt2", word_cnt, 2);
        tick();

        run_random("backpressure", 10, 0, 40);
        run_random("mixed_uid", 12, 25, 20);
        run_random("saturate", 260, 0, 0);

`ifdef NOVACORE_CFG_CHECKSUM_EN
        run_chk(58'h7, 1'b0);
        run_chk(58'h6, 1'b1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/novacore_cfg_sequencer.md
# novacore_cfg_sequencer

Configuration sequencer for the NovaCORE fabric. It accepts configuration words from a host over a valid/ready stream and serialises them onto the fabric configuration port (`mode`, `c_bus`, `c_uid`, `c_clk`, `c_dimension`, `c_dimswitch`). It generates the `c_clk` strobes and `c_dimswitch` pulses itself, and returns the fabric to run mode when the last word is written. It sits between the host command interface and the fabric top level, and is the only driver of the fabric configuration port.

## Interface
Parameters:
- BUS_W, 58, configuration word width (`c_bus`)
- UID_W, 8, cell UID width
- DIM_W, 2, dimension field width
- NUM_CELLS, 49, number of addressable cells; valid UIDs are 0..NUM_CELLS-1
- HALF_PER, 2, length of one `c_clk` high or low phase, in `clk` cycles; must be ≥1
- CNT_W, 8, width of the word counter

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- rst_n  in  1  reset, synchronous, active-low
- start  in  1  one-cycle pulse that begins a configuration session
- abort  in  1  one-cycle pulse that ends the session immediately
- h_valid  in  1  host word valid
- h_ready  out  1  sequencer can accept a word
- h_data  in  BUS_W  configuration payload
- h_uid  in  UID_W  target cell UID
- h_dim  in  DIM_W  dimension for this word
- h_last  in  1  marks the final word of the session
- mode  out  1  1 = run, 0 = configure
- c_bus  out  BUS_W  configuration word to the fabric
- c_uid  out  UID_W  target UID to the fabric
- c_clk  out  1  configuration strobe
- c_dimension  out  DIM_W  current dimension
- c_dimswitch  out  1  dimension-change strobe
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse when a session completes normally
- err  out  1  sticky bad-UID flag; cleared by `start`
- word_cnt  out  CNT_W  number of words written in the current session; saturates at all-ones

## Operation
States are IDLE, LOAD, DSW, SETUP, HI, LO and DONE.

- **IDLE**
  - Outputs: `mode`=1, `h_ready`=0.
  - On `start`: clear `err` and `word_cnt`, then go to LOAD.
- **LOAD**
  - `h_ready`=1 and `mode`=0.
  - A handshake occurs when `h_valid` and `h_ready` are both high. On a handshake, register `h_data`→`c_bus`, `h_uid`→`c_uid`, and the pending dim and last flags.
  - If `h_uid` ≥ NUM_CELLS: the word is dropped, `err` is set, and the block stays in LOAD. If that word carried `h_last`, go to DONE instead.
  - Else, if `h_dim` ≠ `c_dimension`: go to DSW.
  - Otherwise: go to SETUP.
- **DSW**
  - `c_dimswitch`=1 for HALF_PER cycles.
  - `c_dimension` takes the new dim on DSW entry.
  - Then go to SETUP.
- **SETUP**
  - One cycle with the bus stable and `c_clk`=0.
  - Then go to HI.
- **HI**
  - `c_clk`=1 for HALF_PER cycles.
  - `word_cnt` increments on HI entry.
- **LO**
  - `c_clk`=0 for HALF_PER cycles.
  - Then go to DONE if the word carried `h_last`, else to LOAD.
- **DONE**
  - `done`=1 for one cycle and `mode` returns to 1.
  - Then go to IDLE.

Other rules:
- `abort` in any state returns to IDLE on the next cycle, with `c_clk`=0, `c_dimswitch`=0 and `mode`=1. `abort` takes priority over `start` and over a handshake in the same cycle.
- `start` outside IDLE is ignored.
- `c_bus`, `c_uid` and `c_dimension` hold their last values outside a session. They are never changed while `c_clk`=1.

## Timing
- Reset values: `mode`=1, `busy`=0, `done`=0, `err`=0, `h_ready`=0; `c_bus`, `c_uid`, `c_clk`, `c_dimension`, `c_dimswitch` and `word_cnt` are all 0. The state is IDLE.
- All outputs are registered.
- `start` in cycle T gives `h_ready`=1 and `mode`=0 in cycle T+1.
- For a word accepted in cycle T with no dimension change:
  - SETUP runs in T+1.
  - `c_clk` is high in cycles T+2 .. T+1+HALF_PER, then low for HALF_PER cycles.
  - `h_ready` returns in cycle T+2+2·HALF_PER.
- Per-word cost is 2·HALF_PER+2 cycles, plus HALF_PER cycles when a dimension switch occurs. With defaults this is 6 or 8 cycles.
- After the last word, DONE follows LO directly. `done` and `mode`=1 appear in the same cycle.

## Configuration
Macro `NOVACORE_CFG_CHECKSUM_EN`.
- **Defined:**
  - Adds the input `exp_chk [BUS_W-1:0]`, sampled on `start`, and the output `chk_err` (reset 0, cleared by `start`).
  - A running XOR is taken over every word strobed in HI.
  - On DONE entry, `chk_err` is set if the XOR differs from `exp_chk`.
  - Words dropped for a bad UID are excluded from the XOR.
- **Undefined:** neither port nor the XOR logic exists.

## Structure
- Package `novacore_cfg_pkg` holds:
  - the state enum;
  - constants for the default BUS_W, UID_W and DIM_W;
  - the packed host-word struct {data, uid, dim, last}.
- Sub-module `novacore_cfg_halfper_timer`: a down-counter loaded with HALF_PER-1 that asserts `expire` on its terminal cycle. One instance is shared by DSW, HI and LO.

## Test plan
- **Single word.** Reset, `start`, one word with uid=5, dim=0, last=1, data=0x2A.
  - `c_clk` is high in cycles T+2..T+3.
  - `done` fires in cycle T+6.
  - `word_cnt`=1 and `mode`=1 afterwards.
- **Dimension change.** Two words with dim 0 then 2.
  - `c_dimswitch` is high for 2 cycles before the second SETUP.
  - `c_dimension`=2.
  - The second word takes 8 cycles.
- **Bad UID.** Three words with uids 3, 49, 7.
  - `err`=1 and `word_cnt`=2.
  - Only 2 `c_clk` pulses occur.
  - The second word produces no strobe.
- **Abort mid-pulse.** `abort` while in HI.
  - Next cycle: `c_clk`=0, `mode`=1, `busy`=0, no `done`.
  - A following `start` runs normally.
- **Backpressure.** `h_valid` toggled randomly with 10 words.
  - Exactly 10 strobes.
  - `c_bus` is unchanged while `c_clk`=1.
  - `word_cnt`=10.
- **Checksum (macro on).** Words 0x1, 0x2, 0x4 with `exp_chk`=0x7 → `chk_err`=0. The same words with `exp_chk`=0x6 → `chk_err`=1.
